// File: rtl/fifo_fwft_reader.sv
// Read-side FWFT adapter for the dual-clock FIFO: credit-limited read requests, in-flight tracking, small output buffer.
// Define FIFO_RD_DATA_REG_EN when the FIFO memory output is registered (read latency 2, buffer depth 3).
module fifo_fwft_reader #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_rd_en,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_level
);

`ifdef FIFO_RD_DATA_REG_EN
    localparam int RL        = 2;
    localparam int DEPTH_BUF = 3;
`else
    localparam int RL        = 1;
    localparam int DEPTH_BUF = 2;
`endif

    localparam logic [1:0] DEPTH_OCC = 2'(DEPTH_BUF);
    localparam logic [1:0] LAST_PTR  = 2'(DEPTH_BUF - 1);

    logic [WIDTH-1:0] mem [4];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [1:0]       count;
    logic [RL-1:0]    inflight;

    logic             push;
    logic             pop;
    logic             accept;
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic [1:0]       count_next;
    logic [1:0]       head_next;
    logic [1:0]       tail_next;
    logic [1:0]       remaining;
    logic [WIDTH-1:0] head_data_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    // Occupancy never exceeds 3, so 2-bit arithmetic is exact.
    always_comb begin
        pop  = o_valid & i_ready;
        push = inflight[RL-1];
        occ  = count;
        for (int i = 0; i < RL; i++) begin
            occ = occ + 2'(inflight[i]);
        end
        o_rd_en        = i_rst & ((occ < DEPTH_OCC) | ((occ == DEPTH_OCC) & pop));
        accept         = o_rd_en & ~i_empty;
        occ_next       = occ + 2'(accept) - 2'(pop);
        count_next     = count + 2'(push) - 2'(pop);
        head_next      = pop  ? ptr_inc(head) : head;
        tail_next      = push ? ptr_inc(tail) : tail;
        remaining      = count - 2'(pop);
        // With nothing left behind the popped word, the word landing now becomes head.
        head_data_next = (remaining == 2'd0) ? i_rd_data : mem[head_next];
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[tail] <= i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_level  <= '0;
        end else begin
            inflight <= RL'({inflight, accept});
            head     <= head_next;
            tail     <= tail_next;
            count    <= count_next;
            o_valid  <= (count_next != 2'd0);
            if (count_next != 2'd0) begin
                o_data <= head_data_next;
            end
            o_level  <= occ_next;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(push && (count == DEPTH_OCC)));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(pop && (count == 2'd0)));
    a_level_bound: assert property (@(posedge i_clk) disable iff (!i_rst)
        (o_level <= DEPTH_OCC));

endmodule
